// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus initiator: FSM states, op codes,
// GPIO/ID register map addresses and the idle bus values.
package reg_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_WAIT,
    RMW_WR,
    RSP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  localparam logic [2:0] CNAME    = 3'b000;
  localparam logic [2:0] CVERSION = 3'b001;
  localparam logic [2:0] TRISTATE = 3'b010;
  localparam logic [2:0] PINSTATE = 3'b011;
  localparam logic [2:0] INTMASK  = 3'b100;
  localparam logic [2:0] DATAREG  = 3'b101;
  localparam logic [2:0] SCRATCH  = 3'b110;

  localparam logic       IDLE_R_WN = 1'b1;
  localparam logic [3:0] IDLE_WBEN = 4'h0;
  localparam logic [3:0] RMW_WBEN  = 4'hF;

endpackage

// File: rtl/reg_bus_master.sv
// Register-bus initiator: turns core read/write/set/clear requests into
// addr/wben/r_wn/wdata cycles. Set/clear need REG_BUS_MASTER_RMW_EN defined.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_wben,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wben,
  output logic              bus_r_wn,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;
  logic             is_write;

`ifdef REG_BUS_MASTER_RMW_EN
  logic [1:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  assign is_write = (req_op == OP_WRITE);
`else
  // Without read-modify-write only op[0] matters: 10 reads, 11 writes.
  logic unused_op;
  assign unused_op = req_op[1];
  assign is_write  = req_op[0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bus_addr  <= '0;
      bus_wben  <= IDLE_WBEN;
      bus_r_wn  <= IDLE_R_WN;
      bus_wdata <= '0;
`ifdef REG_BUS_MASTER_RMW_EN
      op_q      <= OP_READ;
      wdata_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            bus_addr  <= req_addr;
`ifdef REG_BUS_MASTER_RMW_EN
            op_q      <= req_op;
            wdata_q   <= req_wdata;
`endif
            if (is_write) begin
              state     <= WR;
              bus_r_wn  <= 1'b0;
              bus_wdata <= req_wdata;
              bus_wben  <= req_wben;
            end else begin
              state <= RD_ADDR;
            end
          end
        end
        WR: begin
          bus_r_wn  <= IDLE_R_WN;
          bus_wben  <= IDLE_WBEN;
          bus_wdata <= '0;
          rsp_rdata <= '0;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RD_ADDR: begin
          lat_cnt <= '0;
          state   <= RD_WAIT;
        end
        // bus_addr stays on the bus until the registered read data is taken.
        RD_WAIT: begin
          if (lat_cnt == LAST_CNT) begin
            rsp_rdata <= bus_rdata;
`ifdef REG_BUS_MASTER_RMW_EN
            if (op_q == OP_SET || op_q == OP_CLR) begin
              state     <= RMW_WR;
              bus_r_wn  <= 1'b0;
              bus_wben  <= RMW_WBEN;
              bus_wdata <= (op_q == OP_CLR) ? (bus_rdata & ~wdata_q)
                                            : (bus_rdata | wdata_q);
            end else begin
              rsp_valid <= 1'b1;
              state     <= RSP;
            end
`else
            rsp_valid <= 1'b1;
            state     <= RSP;
`endif
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
`ifdef REG_BUS_MASTER_RMW_EN
        RMW_WR: begin
          bus_r_wn  <= IDLE_R_WN;
          bus_wben  <= IDLE_WBEN;
          bus_wdata <= '0;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
`endif
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master against a behavioural GPIO/ID register
// block; RMW cases follow REG_BUS_MASTER_RMW_EN.
`timescale 1ns/1ps
module tb_reg_bus_master;
  import reg_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wben;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [2:0]  bus_addr;
  logic [3:0]  bus_wben;
  logic        bus_r_wn;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int strobe_cnt = 0;
  int idle_viol = 0;
  logic [31:0] exp_q[$];

  logic [31:0] tri_r = 32'h0;
  logic [31:0] int_r = 32'h0;
  logic [31:0] data_r = 32'h0;
  logic [31:0] scratch_r = 32'h0;

  reg_bus_master #(.ADDR_W(3), .DATA_W(32), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wben(req_wben),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .bus_addr(bus_addr), .bus_wben(bus_wben), .bus_r_wn(bus_r_wn),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      CNAME:    return 32'h48524A44;
      CVERSION: return 32'h00000001;
      TRISTATE: return tri_r;
      PINSTATE: return 32'h00000000;
      INTMASK:  return int_r;
      DATAREG:  return data_r;
      SCRATCH:  return scratch_r;
      default:  return 32'h00000000;
    endcase
  endfunction

  // Register block model: registered read (one cycle), read-only addresses ignore writes.
  always @(posedge clk) begin
    bus_rdata <= model_read(bus_addr);
    if (bus_r_wn === 1'b0) begin
      case (bus_addr)
        TRISTATE: tri_r     <= merge(tri_r, bus_wdata, bus_wben);
        INTMASK:  int_r     <= merge(int_r, bus_wdata, bus_wben);
        DATAREG:  data_r    <= merge(data_r, bus_wdata, bus_wben);
        SCRATCH:  scratch_r <= merge(scratch_r, bus_wdata, bus_wben);
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_r_wn === 1'b0) strobe_cnt <= strobe_cnt + 1;
    if (bus_r_wn === 1'b1 && (bus_wben !== 4'h0 || bus_wdata !== 32'h0)) idle_viol <= idle_viol + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wben, input logic [31:0] exp_rdata);
    int budget = 0;
    req_op = op; req_addr = addr; req_wdata = wdata; req_wben = wben; req_valid = 1'b1;
    while (req_ready !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("accept_seen", 32'(budget < 40), 32'd1);
    accept_cyc = cyc;
    exp_q.push_back(exp_rdata);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = 3'($urandom); req_wdata = $urandom; req_wben = 4'($urandom);
  endtask

  task automatic waitResponse(input string tag, input int exp_lat, input int stall);
    int budget = 0;
    logic [31:0] exp_data;
    rsp_ready = (stall == 0);
    while (rsp_valid !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({tag, "_rsp_seen"}, 32'(budget < 40), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cyc - accept_cyc), 32'(exp_lat));
    exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    checkOutput({tag, "_rdata"}, rsp_rdata, exp_data);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput({tag, "_stall_ctrl"}, {rsp_valid, req_ready, bus_r_wn, bus_wben}, {1'b1, 1'b0, 1'b1, 4'h0});
      checkOutput({tag, "_stall_rdata"}, rsp_rdata, exp_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_done"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    int prev_accept;
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = 3'b000;
    req_wdata = 32'h0; req_wben = 4'h0; rsp_ready = 1'b1;

    @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 0);
    checkOutput("reset_bus_ctrl", {bus_addr, bus_wben, bus_r_wn}, {3'b000, 4'h0, 1'b1});
    checkOutput("reset_bus_wdata", bus_wdata, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("release_req_ready", req_ready, 1);

    $display("[TB] write then read scratch");
    s0 = strobe_cnt;
    applyStimulus(OP_WRITE, SCRATCH, 32'hDEADBEEF, 4'hF, 32'h0);
    waitResponse("wr_scratch", 2, 0);
    checkOutput("wr_scratch_strobes", 32'(strobe_cnt - s0), 1);
    s0 = strobe_cnt;
    applyStimulus(OP_READ, SCRATCH, 32'h0, 4'h0, 32'hDEADBEEF);
    waitResponse("rd_scratch", 3, 0);
    checkOutput("rd_scratch_strobes", 32'(strobe_cnt - s0), 0);

    $display("[TB] back-to-back writes");
    applyStimulus(OP_WRITE, TRISTATE, 32'h12345678, 4'hF, 32'h0);
    prev_accept = accept_cyc;
    waitResponse("b2b_wr0", 2, 0);
    applyStimulus(OP_WRITE, INTMASK, 32'h00000003, 4'hF, 32'h0);
    checkOutput("b2b_gap", 32'(accept_cyc - prev_accept), 3);
    waitResponse("b2b_wr1", 2, 0);
    applyStimulus(OP_READ, TRISTATE, 32'h0, 4'h0, 32'h12345678);
    waitResponse("rd_tristate", 3, 0);

    $display("[TB] ID registers");
    applyStimulus(OP_READ, CNAME, 32'h0, 4'h0, 32'h48524A44);
    waitResponse("rd_cname", 3, 0);
    applyStimulus(OP_READ, CVERSION, 32'h0, 4'h0, 32'h00000001);
    waitResponse("rd_cversion", 3, 0);

    $display("[TB] partial byte write");
    applyStimulus(OP_WRITE, DATAREG, 32'h0000ABCD, 4'b0001, 32'h0);
    waitResponse("wr_datareg", 2, 0);
    applyStimulus(OP_READ, DATAREG, 32'h0, 4'h0, 32'h000000CD);
    waitResponse("rd_datareg", 3, 0);

    $display("[TB] read-only target and empty byte enables");
    s0 = strobe_cnt;
    applyStimulus(OP_WRITE, CVERSION, 32'hFFFFFFFF, 4'hF, 32'h0);
    waitResponse("wr_readonly", 2, 0);
    checkOutput("wr_readonly_strobes", 32'(strobe_cnt - s0), 1);
    applyStimulus(OP_READ, CVERSION, 32'h0, 4'h0, 32'h00000001);
    waitResponse("rd_cversion2", 3, 0);
    s0 = strobe_cnt;
    applyStimulus(OP_WRITE, SCRATCH, 32'h11111111, 4'h0, 32'h0);
    waitResponse("wr_nowben", 2, 0);
    checkOutput("wr_nowben_strobes", 32'(strobe_cnt - s0), 1);

    $display("[TB] response back-pressure");
    applyStimulus(OP_READ, SCRATCH, 32'h0, 4'h0, 32'hDEADBEEF);
    waitResponse("rd_stall", 3, 4);

`ifdef REG_BUS_MASTER_RMW_EN
    $display("[TB] set/clear");
    applyStimulus(OP_WRITE, SCRATCH, 32'h000000F0, 4'hF, 32'h0);
    waitResponse("wr_scr_f0", 2, 0);
    s0 = strobe_cnt;
    applyStimulus(OP_SET, SCRATCH, 32'h0000000F, 4'h0, 32'h000000F0);
    waitResponse("set_scr", 4, 0);
    checkOutput("set_scr_strobes", 32'(strobe_cnt - s0), 1);
    applyStimulus(OP_READ, SCRATCH, 32'h0, 4'h0, 32'h000000FF);
    waitResponse("rd_after_set", 3, 0);
    applyStimulus(OP_CLR, SCRATCH, 32'h000000F0, 4'h0, 32'h000000FF);
    waitResponse("clr_scr", 4, 0);
    applyStimulus(OP_READ, SCRATCH, 32'h0, 4'h0, 32'h0000000F);
    waitResponse("rd_after_clr", 3, 0);
`else
    $display("[TB] op aliases without set/clear");
    applyStimulus(2'b10, CNAME, 32'hFFFFFFFF, 4'hF, 32'h48524A44);
    waitResponse("alias_rd", 3, 0);
    s0 = strobe_cnt;
    applyStimulus(2'b11, SCRATCH, 32'h00000055, 4'hF, 32'h0);
    waitResponse("alias_wr", 2, 0);
    checkOutput("alias_wr_strobes", 32'(strobe_cnt - s0), 1);
    applyStimulus(OP_READ, SCRATCH, 32'h0, 4'h0, 32'h00000055);
    waitResponse("rd_after_alias", 3, 0);
`endif

    $display("[TB] reset during read wait");
    applyStimulus(OP_READ, SCRATCH, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrst_ctrl", {rsp_valid, req_ready, bus_r_wn, bus_wben}, {1'b0, 1'b0, 1'b1, 4'h0});
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_release_ready", req_ready, 1);
    applyStimulus(OP_READ, CNAME, 32'h0, 4'h0, 32'h48524A44);
    waitResponse("rd_after_rst", 3, 0);

    checkOutput("idle_bus_violations", 32'(idle_viol), 0);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
